// File: rtl/adxl355_sync_meter.sv
// Measures the ADXL355 SYNC rate and phase against GPS PPS once per second and
// trims the SYNC generator's phase-accumulator increment toward the nominal rate.
`timescale 1ns/1ps
module adxl355_sync_meter #(
  parameter int clk_out0_hz    = 40000000,
  parameter int clk_sync_hz    = 1000,
  parameter int pa_sync_bits   = 24,
  parameter int pa_inc_nominal = 32768,
  parameter int trim_step      = 1,
  parameter int trim_range     = 256,
  parameter int lock_seconds   = 4,
  parameter int cnt_bits       = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_pps,
  input  logic                           i_sync,
  output logic [cnt_bits-1:0]            o_sync_count,
  output logic [$clog2(clk_out0_hz)-1:0] o_phase,
  output logic                           o_valid,
  output logic [pa_sync_bits-1:0]        o_pa_inc,
  output logic                           o_locked,
  output logic                           o_pps_lost
);

  localparam int PH_W = $clog2(clk_out0_hz);
  localparam int WD_W = $clog2(2 * clk_out0_hz + 1);
  localparam int LK_W = $clog2(lock_seconds + 1);
  localparam int PA_W = pa_sync_bits;

  localparam logic [cnt_bits-1:0]      CNT_NOM   = cnt_bits'(clk_sync_hz);
  localparam logic [WD_W-1:0]          WD_LAST   = WD_W'(2 * clk_out0_hz - 1);
  localparam logic [LK_W-1:0]          LOCK_THR  = LK_W'(lock_seconds);
  localparam logic signed [PA_W+1:0]   PA_MAX    = (PA_W+2)'(pa_inc_nominal + trim_range);
  localparam logic signed [PA_W+1:0]   PA_MIN    = (PA_W+2)'(pa_inc_nominal - trim_range);
  localparam logic signed [PA_W+1:0]   TRIM_STEP = (PA_W+2)'(trim_step);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOST} state_t;

  state_t state, state_nxt;

  logic pps_p0, pps_p1, pps_p2, pps_ev_p3;
  logic sync_p0, sync_p1, sync_p2, sync_ev_p3;

  logic [cnt_bits-1:0] win_cnt;
  logic [PH_W-1:0]     ph_cnt;
  logic [PH_W-1:0]     ph_lat;
  logic                got_sync;
  logic [WD_W-1:0]     wd_cnt;
  logic [LK_W-1:0]     lock_cnt;
  logic [LK_W-1:0]     lock_nxt;
  logic                timeout;

  function automatic logic [cnt_bits-1:0] cnt_sat_inc(input logic [cnt_bits-1:0] v);
    return (&v) ? v : v + cnt_bits'(1);
  endfunction

  function automatic logic [PH_W-1:0] ph_sat_inc(input logic [PH_W-1:0] v);
    return (&v) ? v : v + PH_W'(1);
  endfunction

  function automatic logic [LK_W-1:0] lock_sat_inc(input logic [LK_W-1:0] v);
    return (v >= LOCK_THR) ? v : v + LK_W'(1);
  endfunction

  // Clamp a widened signed increment to the allowed trim window.
  function automatic logic [PA_W-1:0] clamp_inc(input logic signed [PA_W+1:0] v);
    logic signed [PA_W+1:0] c;
    c = v;
    if (c > PA_MAX) c = PA_MAX;
    if (c < PA_MIN) c = PA_MIN;
    return c[PA_W-1:0];
  endfunction

  function automatic logic [PA_W-1:0] trim_inc(input logic [PA_W-1:0] cur,
                                               input logic [cnt_bits-1:0] cnt);
    logic signed [PA_W+1:0] w;
    w = signed'({2'b00, cur});
    if (cnt < CNT_NOM)      w = w + TRIM_STEP;
    else if (cnt > CNT_NOM) w = w - TRIM_STEP;
    return clamp_inc(w);
  endfunction

  // Stage p0..p2: two-flop synchronizers plus delayed copy; p3: registered rising-edge events
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pps_p0     <= 1'b0;
      pps_p1     <= 1'b0;
      pps_p2     <= 1'b0;
      pps_ev_p3  <= 1'b0;
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      sync_p2    <= 1'b0;
      sync_ev_p3 <= 1'b0;
    end else begin
      pps_p0     <= i_pps;
      pps_p1     <= pps_p0;
      pps_p2     <= pps_p1;
      pps_ev_p3  <= pps_p1 & ~pps_p2;
      sync_p0    <= i_sync;
      sync_p1    <= sync_p0;
      sync_p2    <= sync_p1;
      sync_ev_p3 <= sync_p1 & ~sync_p2;
    end
  end

  assign timeout  = (wd_cnt == WD_LAST);
  assign lock_nxt = (win_cnt == CNT_NOM) ? lock_sat_inc(lock_cnt) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (pps_ev_p3) state_nxt = S_MEASURE;
      S_MEASURE: if (!pps_ev_p3 && timeout) state_nxt = S_LOST;
      S_LOST:    if (pps_ev_p3) state_nxt = S_MEASURE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Stage p4: window accumulation and once-per-second output update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_cnt      <= '0;
      ph_cnt       <= '0;
      ph_lat       <= '1;
      got_sync     <= 1'b0;
      wd_cnt       <= '0;
      lock_cnt     <= '0;
      o_sync_count <= '0;
      o_phase      <= '0;
      o_valid      <= 1'b0;
      o_pa_inc     <= PA_W'(pa_inc_nominal);
      o_locked     <= 1'b0;
      o_pps_lost   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (pps_ev_p3) begin
        // A SYNC edge coincident with PPS opens the new window, not the closing one.
        win_cnt    <= sync_ev_p3 ? cnt_bits'(1) : '0;
        ph_lat     <= sync_ev_p3 ? '0 : '1;
        got_sync   <= sync_ev_p3;
        ph_cnt     <= PH_W'(1);
        wd_cnt     <= WD_W'(1);
        o_pps_lost <= 1'b0;
        if (state == S_MEASURE) begin
          o_valid      <= 1'b1;
          o_sync_count <= win_cnt;
          o_phase      <= ph_lat;
          o_pa_inc     <= trim_inc(o_pa_inc, win_cnt);
          lock_cnt     <= lock_nxt;
          o_locked     <= (lock_nxt >= LOCK_THR);
        end
      end else if (state == S_MEASURE) begin
        if (sync_ev_p3) begin
          win_cnt <= cnt_sat_inc(win_cnt);
          if (!got_sync) begin
            ph_lat   <= ph_cnt;
            got_sync <= 1'b1;
          end
        end
        ph_cnt <= ph_sat_inc(ph_cnt);
        wd_cnt <= wd_cnt + WD_W'(1);
        if (timeout) begin
          o_pps_lost <= 1'b1;
          o_locked   <= 1'b0;
          lock_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adxl355_sync_meter.sv
// Directed-sequence bench with randomized SYNC placement, checked against a
// per-second arithmetic model of rate, phase, trim, lock and PPS-loss.
`timescale 1ns/1ps
module tb_adxl355_sync_meter;

  localparam int HZ      = 10000;
  localparam int SHZ     = 10;
  localparam int LOCKS   = 2;
  localparam int RANGE   = 4;
  localparam int NOM     = 32768;
  localparam int PH_W    = $clog2(HZ);
  localparam int PH_ONES = (1 << PH_W) - 1;
  localparam int LOST_AT = 2 * HZ + 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pps = 1'b0;
  logic              sync = 1'b0;
  logic [15:0]       sync_count;
  logic [PH_W-1:0]   phase;
  logic              valid;
  logic [23:0]       pa_inc;
  logic              locked;
  logic              pps_lost;

  int n_cmp  = 0;
  int n_fail = 0;

  bit m_win;
  int m_n, m_ph, m_pa, m_lock, m_cnt_out, m_ph_out;

  adxl355_sync_meter #(
    .clk_out0_hz(HZ), .clk_sync_hz(SHZ), .pa_sync_bits(24), .pa_inc_nominal(NOM),
    .trim_step(1), .trim_range(RANGE), .lock_seconds(LOCKS), .cnt_bits(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pps(pps), .i_sync(sync),
    .o_sync_count(sync_count), .o_phase(phase), .o_valid(valid),
    .o_pa_inc(pa_inc), .o_locked(locked), .o_pps_lost(pps_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},  32'(sync_count), 32'(0));
    check({tag, "_phase"},  32'(phase),      32'(0));
    check({tag, "_valid"},  32'(valid),      32'(0));
    check({tag, "_pa_inc"}, 32'(pa_inc),     32'(NOM));
    check({tag, "_locked"}, 32'(locked),     32'(0));
    check({tag, "_lost"},   32'(pps_lost),   32'(0));
  endtask

  task automatic model_reset();
    m_win = 1'b0; m_n = 0; m_ph = PH_ONES; m_pa = NOM; m_lock = 0;
    m_cnt_out = 0; m_ph_out = 0;
  endtask

  // One PPS period: PPS pin rises at c=0, SYNC pulses (5 cycles high) at first+i*spacing.
  task automatic run_period(input int len, input int nsync, input int first, input int spacing);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == 3 || c == 5) check("valid_quiet", 32'(valid), 32'(0));
      if (c == 4) begin
        if (m_win) begin
          if (m_n < SHZ) m_pa++;
          else if (m_n > SHZ) m_pa--;
          if (m_pa > NOM + RANGE) m_pa = NOM + RANGE;
          if (m_pa < NOM - RANGE) m_pa = NOM - RANGE;
          m_lock    = (m_n == SHZ) ? m_lock + 1 : 0;
          m_cnt_out = m_n;
          m_ph_out  = m_ph;
          check("valid_strobe", 32'(valid),      32'(1));
          check("sync_count",   32'(sync_count), 32'(m_cnt_out));
          check("phase",        32'(phase),      32'(m_ph_out));
        end else begin
          check("valid_absent", 32'(valid), 32'(0));
        end
        check("pa_inc", 32'(pa_inc),   32'(m_pa));
        check("locked", 32'(locked),   32'(m_lock >= LOCKS));
        check("lost_clear", 32'(pps_lost), 32'(0));
        m_win = 1'b1;
        m_n   = nsync;
        m_ph  = (nsync > 0) ? first : PH_ONES;
      end
      if (c == LOST_AT - 1) check("lost_early", 32'(pps_lost), 32'(0));
      if (c == LOST_AT) begin
        check("lost_set",    32'(pps_lost),   32'(1));
        check("lost_locked", 32'(locked),     32'(0));
        check("lost_pa",     32'(pa_inc),     32'(m_pa));
        check("lost_count",  32'(sync_count), 32'(m_cnt_out));
        check("lost_phase",  32'(phase),      32'(m_ph_out));
        m_win  = 1'b0;
        m_lock = 0;
      end
      pps = (c < 50);
      sync = 1'b0;
      for (int i = 0; i < nsync; i++)
        if (c >= first + i * spacing && c < first + i * spacing + 5) sync = 1'b1;
    end
  endtask

  task automatic run_rand(input int nsync);
    run_period(1000, nsync, $urandom_range(1, 100), $urandom_range(60, 80));
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    repeat (6) run_period(1000, 10, 100, 80);
    repeat (6) run_rand(9);
    repeat (10) run_rand(11);
    repeat (3) run_period(1000, 10, 100, 80);

    run_period(LOST_AT + 500, 10, 100, 80);
    run_period(1000, 10, 100, 80);
    run_period(1000, 10, 0, 80);
    run_period(1000, 0, 0, 0);
    run_period(1000, 10, 50, 70);
    repeat (4) run_rand($urandom_range(8, 12));

    run_period(500, 10, 100, 80);
    @(negedge clk);
    #2 rst_n = 1'b0;
    pps = 1'b0;
    sync = 1'b0;
    #1 check_reset_values("mid_reset");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_period(1000, 10, 100, 80);
    run_period(1000, 10, 40, 75);
    run_period(10, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
